// File: rtl/polar_stats_if.sv
// polar_stats_if -- bundle of the polar_stats sample and summary signals.
//   in_valid / in_mag / in_phase : CORDIC sample stream (into the block)
//   out_*                        : per-burst summary (out of the block)
// Modports:
//   master : the upstream/observer side; it drives the samples and reads the summary
//   slave  : the polar_stats block itself
interface polar_stats_if;
  logic        in_valid;
  logic [11:0] in_mag;
  logic [20:0] in_phase;
  logic        out_valid;
  logic [11:0] out_peak_mag;
  logic [20:0] out_peak_phase;
  logic [9:0]  out_peak_idx;
  logic [10:0] out_count;
  logic [21:0] out_mag_sum;
  logic [1:0]  out_quad_idx;
  logic [10:0] out_quad_cnt;
  logic        out_ovf;

  modport master (
    output in_valid, in_mag, in_phase,
    input  out_valid, out_peak_mag, out_peak_phase, out_peak_idx, out_count,
           out_mag_sum, out_quad_idx, out_quad_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_mag, in_phase,
    output out_valid, out_peak_mag, out_peak_phase, out_peak_idx, out_count,
           out_mag_sum, out_quad_idx, out_quad_cnt, out_ovf
  );
endinterface

// File: rtl/polar_stats.sv
// polar_stats -- burst statistics over a stream of polar (magnitude/phase) samples.
// A burst is a contiguous run of in_valid. The block tracks the peak magnitude and
// its phase and index, the sample count, the magnitude sum and per-quadrant counts.
// Once the burst ends it presents the summary for 4 cycles, stepping out_quad_idx
// through 0..3. All outputs come straight from flops and read 0 outside the window.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : polar_stats_if.slave (samples in, summary out)
module polar_stats #(
  parameter int MAX_SAMPLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  polar_stats_if.slave  bus
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_SAMPLES);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t      state;
  logic [1:0]  out_cnt;
  logic [10:0] cnt;
  logic [11:0] peak_mag;
  logic [20:0] peak_phase;
  logic [9:0]  peak_idx;
  logic [21:0] mag_sum;
  logic [10:0] quad_cnt [4];
  logic        ovf;

  // summary registers driving the outputs directly
  logic        rep_valid;
  logic [11:0] rep_peak_mag;
  logic [20:0] rep_peak_phase;
  logic [9:0]  rep_peak_idx;
  logic [10:0] rep_count;
  logic [21:0] rep_mag_sum;
  logic [1:0]  rep_quad_idx;
  logic [10:0] rep_quad_cnt;
  logic        rep_ovf;

  logic [1:0]  quad;
  logic [1:0]  out_cnt_nxt;

  assign quad        = bus.in_phase[20:19];
  assign out_cnt_nxt = out_cnt + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      out_cnt        <= 2'd0;
      cnt            <= 11'd0;
      peak_mag       <= 12'd0;
      peak_phase     <= 21'd0;
      peak_idx       <= 10'd0;
      mag_sum        <= 22'd0;
      for (int q = 0; q < 4; q++) quad_cnt[q] <= 11'd0;
      ovf            <= 1'b0;
      rep_valid      <= 1'b0;
      rep_peak_mag   <= 12'd0;
      rep_peak_phase <= 21'd0;
      rep_peak_idx   <= 10'd0;
      rep_count      <= 11'd0;
      rep_mag_sum    <= 22'd0;
      rep_quad_idx   <= 2'd0;
      rep_quad_cnt   <= 11'd0;
      rep_ovf        <= 1'b0;
    end else begin
      case (state)
        // IDLE: the first valid sample opens a burst; the accumulators are
        // loaded with it directly rather than cleared and then added to.
        IDLE: begin
          if (bus.in_valid) begin
            state      <= ACC;
            cnt        <= 11'd1;
            peak_mag   <= bus.in_mag;
            peak_phase <= bus.in_phase;
            peak_idx   <= 10'd0;
            mag_sum    <= 22'(bus.in_mag);
            for (int q = 0; q < 4; q++)
              quad_cnt[q] <= (2'(q) == quad) ? 11'd1 : 11'd0;
            ovf        <= 1'b0;
          end
        end

        // ACC: accumulate until in_valid drops; samples beyond the limit only flag ovf.
        ACC: begin
          if (bus.in_valid) begin
            if (cnt < MAX_CNT) begin
              cnt            <= cnt + 11'd1;
              mag_sum        <= mag_sum + 22'(bus.in_mag);
              quad_cnt[quad] <= quad_cnt[quad] + 11'd1;
              // strict compare keeps the earliest of equal peaks
              if (bus.in_mag > peak_mag) begin
                peak_mag   <= bus.in_mag;
                peak_phase <= bus.in_phase;
                peak_idx   <= cnt[9:0];
              end
            end else begin
              ovf <= 1'b1;
            end
          end else begin
            state          <= OUT;
            out_cnt        <= 2'd0;
            rep_valid      <= 1'b1;
            rep_peak_mag   <= peak_mag;
            rep_peak_phase <= peak_phase;
            rep_peak_idx   <= peak_idx;
            rep_count      <= cnt;
            rep_mag_sum    <= mag_sum;
            rep_ovf        <= ovf;
            rep_quad_idx   <= 2'd0;
            rep_quad_cnt   <= quad_cnt[0];
          end
        end

        // OUT: step the quadrant report; in_valid is ignored here. The summary
        // was loaded on entry, so the window spans out_cnt 0..3 = 4 cycles.
        OUT: begin
          if (out_cnt == 2'd3) begin
            state          <= IDLE;
            rep_valid      <= 1'b0;
            rep_peak_mag   <= 12'd0;
            rep_peak_phase <= 21'd0;
            rep_peak_idx   <= 10'd0;
            rep_count      <= 11'd0;
            rep_mag_sum    <= 22'd0;
            rep_quad_idx   <= 2'd0;
            rep_quad_cnt   <= 11'd0;
            rep_ovf        <= 1'b0;
          end else begin
            out_cnt      <= out_cnt_nxt;
            rep_quad_idx <= out_cnt_nxt;
            rep_quad_cnt <= quad_cnt[out_cnt_nxt];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid      = rep_valid;
  assign bus.out_peak_mag   = rep_peak_mag;
  assign bus.out_peak_phase = rep_peak_phase;
  assign bus.out_peak_idx   = rep_peak_idx;
  assign bus.out_count      = rep_count;
  assign bus.out_mag_sum    = rep_mag_sum;
  assign bus.out_quad_idx   = rep_quad_idx;
  assign bus.out_quad_cnt   = rep_quad_cnt;
  assign bus.out_ovf        = rep_ovf;

endmodule

// File: tb/tb_polar_stats.sv
// tb_polar_stats -- directed bench for polar_stats with hand-computed summaries.
module tb_polar_stats;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  polar_stats_if bus();

  polar_stats #(.MAX_SAMPLES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},      32'(bus.out_valid),      32'd0);
    check({tag, ".peak_mag"},   32'(bus.out_peak_mag),   32'd0);
    check({tag, ".peak_phase"}, 32'(bus.out_peak_phase), 32'd0);
    check({tag, ".peak_idx"},   32'(bus.out_peak_idx),   32'd0);
    check({tag, ".count"},      32'(bus.out_count),      32'd0);
    check({tag, ".mag_sum"},    32'(bus.out_mag_sum),    32'd0);
    check({tag, ".quad_idx"},   32'(bus.out_quad_idx),   32'd0);
    check({tag, ".quad_cnt"},   32'(bus.out_quad_cnt),   32'd0);
    check({tag, ".ovf"},        32'(bus.out_ovf),        32'd0);
  endtask

  // one accepted-sample cycle; returns #1 after the sampling edge
  task automatic send(input logic [11:0] mag, input logic [20:0] phase);
    bus.in_valid = 1'b1;
    bus.in_mag   = mag;
    bus.in_phase = phase;
    @(posedge clk); #1;
  endtask

  task automatic end_burst();
    bus.in_valid = 1'b0;
    bus.in_mag   = 12'd0;
    bus.in_phase = 21'd0;
  endtask

  // Checks the 4-cycle summary window that follows the edge sampling in_valid=0,
  // then that outputs return to 0. With pulse set, in_valid is held high in OUT.
  task automatic check_summary(input string tag,
                               input logic [11:0] pm, input logic [20:0] pp,
                               input logic [9:0] pi, input logic [10:0] c,
                               input logic [21:0] s, input logic ov,
                               input logic [10:0] q0, input logic [10:0] q1,
                               input logic [10:0] q2, input logic [10:0] q3,
                               input bit pulse);
    logic [10:0] qe [4];
    qe[0] = q0; qe[1] = q1; qe[2] = q2; qe[3] = q3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check({tag, ".valid"},      32'(bus.out_valid),      32'd1);
      check({tag, ".quad_idx"},   32'(bus.out_quad_idx),   32'(k));
      check({tag, ".quad_cnt"},   32'(bus.out_quad_cnt),   32'(qe[k]));
      check({tag, ".peak_mag"},   32'(bus.out_peak_mag),   32'(pm));
      check({tag, ".peak_phase"}, 32'(bus.out_peak_phase), 32'(pp));
      check({tag, ".peak_idx"},   32'(bus.out_peak_idx),   32'(pi));
      check({tag, ".count"},      32'(bus.out_count),      32'(c));
      check({tag, ".mag_sum"},    32'(bus.out_mag_sum),    32'(s));
      check({tag, ".ovf"},        32'(bus.out_ovf),        32'(ov));
      if (pulse) begin
        bus.in_valid = 1'b1;
        bus.in_mag   = 12'h7FF;
        bus.in_phase = 21'h080000;
      end
    end
    end_burst();
    @(posedge clk); #1;
    check_zero({tag, ".after"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mag   = 12'd0;
    bus.in_phase = 21'd0;

    // reset state
    #3;
    check_zero("reset");
    #19 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero("idle_after_reset");

    // basic burst: peak in the middle, one sample in each of quadrants 0..2
    send(12'h100, 21'h000000);
    send(12'h300, 21'h080000);
    send(12'h200, 21'h100000);
    end_burst();
    check_summary("basic", 12'h300, 21'h080000, 10'd1, 11'd3, 22'h600, 1'b0,
                  11'd1, 11'd1, 11'd1, 11'd0, 1'b0);

    // back-to-back: equal magnitudes keep the earliest as peak
    send(12'h0FF, 21'h000010);
    send(12'h0FF, 21'h000020);
    send(12'h0FF, 21'h000030);
    end_burst();
    check_summary("ties", 12'h0FF, 21'h000010, 10'd0, 11'd3, 22'h2FD, 1'b0,
                  11'd3, 11'd0, 11'd0, 11'd0, 1'b0);

    // overflow: 1030 samples, only the first 1024 counted
    for (int i = 0; i < 1030; i++) send(12'hFFF, 21'h180000);
    end_burst();
    check_summary("ovf", 12'hFFF, 21'h180000, 10'd0, 11'd1024, 22'h3FFC00, 1'b1,
                  11'd0, 11'd0, 11'd0, 11'd1024, 1'b0);

    // single sample; in_valid held high through OUT must not start a burst
    send(12'h001, 21'h1FFFFF);
    end_burst();
    check_summary("single", 12'h001, 21'h1FFFFF, 10'd0, 11'd1, 22'h001, 1'b0,
                  11'd0, 11'd0, 11'd0, 11'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_second_summary", 32'(bus.out_valid), 32'd0);
    end

    // reset during the second OUT cycle
    send(12'h010, 21'h000000);
    send(12'h020, 21'h000000);
    end_burst();
    @(posedge clk); #1;
    check("pre_rst.valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    check("pre_rst.valid2", 32'(bus.out_valid), 32'd1);
    check("pre_rst.quad_idx", 32'(bus.out_quad_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst.valid", 32'(bus.out_valid), 32'd0);
    end

    // fresh burst after reset: no carry-over from the abandoned one
    send(12'h005, 21'h080000);
    send(12'h007, 21'h1C0000);
    end_burst();
    check_summary("post_rst", 12'h007, 21'h1C0000, 10'd1, 11'd2, 22'h00C, 1'b0,
                  11'd0, 11'd1, 11'd0, 11'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
